random_server: RTL and testbench
================================

Name: random_server

Overview:
- Time-shared front end for the game's single 16-bit LFSR random generator.
- Serves several game-control requesters (duck spawn X, flight direction, speed) one at a time using round-robin arbitration.
- For each draw it advances the LFSR a fixed number of steps, then reduces the sample to the range [0, range) with a fixed-latency restoring remainder.
- Sits between game-control FSMs and the LFSR instance; it owns the LFSR enable.

Parameters:
- N_REQ, 3, number of requesters.
- WIDTH, 16, LFSR width (width of lfsr_random).
- OUT_W, 10, width of range and value; requires OUT_W <= WIDTH.
- STEP_CNT, 4, LFSR shifts per draw, used for decorrelation; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  level request, one bit per requester.
- range  in  N_REQ*OUT_W  packed exclusive upper bounds; requester i uses bits [i*OUT_W +: OUT_W].
- ack  out  N_REQ  one-cycle pulse to the served requester; value is valid in the same cycle.
- value  out  OUT_W  result of the last draw.
- busy  out  1  high whenever the FSM is not in IDLE.
- lfsr_enable  out  1  drives the LFSR enable.
- lfsr_random  in  WIDTH  LFSR state output.

Behaviour:
- Reset values: state IDLE, ack=0, value=0, busy=0, lfsr_enable=0, last_grant=N_REQ-1 (requester 0 wins first), counters=0.
- All outputs are registered.
- FSM states: IDLE, STEP, SAMPLE, REDUCE, DONE.
- IDLE:
  - If req != 0, grant the first set bit searching from last_grant+1 upward with wrap-around.
  - Latch grant index and its range slice; cnt=0; go to STEP.
  - Otherwise stay in IDLE.
- STEP:
  - lfsr_enable=1 for exactly STEP_CNT consecutive cycles, then go to SAMPLE.
  - lfsr_enable is 0 in every other state.
- SAMPLE:
  - rem <= zero-extended lfsr_random[OUT_W-1:0] (2*OUT_W bits).
  - bit index k <= OUT_W-1; go to REDUCE.
- REDUCE (one step per cycle, exactly OUT_W cycles):
  - If rem >= (range_l << k), then rem -= (range_l << k).
  - Decrement k; after k=0 go to DONE.
  - Compare in 2*OUT_W bits; no overflow is possible.
- DONE (one cycle):
  - ack[grant]=1, value=rem[OUT_W-1:0], last_grant=grant.
  - Return to IDLE.
- Latency: ack is high in the cycle following the (STEP_CNT+OUT_W+1)-th rising edge after the granting edge. With default parameters that is 15 edges.
- Throughput: one draw per STEP_CNT+OUT_W+2 cycles.
- Range special cases:
  - range_l == 0: no reduction; value = raw lfsr_random[OUT_W-1:0]. REDUCE still takes OUT_W cycles, so latency is constant.
  - range_l == 1: value=0.
- Range is latched at grant; changes to range during service are ignored.
- req is level-sensitive:
  - A requester must deassert in the cycle after seeing ack.
  - If req[grant] is still high when the FSM is back in IDLE, it counts as a new request. It is arbitrated with lowest priority, because last_grant now points at it.
- A requester dropping req mid-service: the draw still completes and ack is still pulsed.
- Simultaneous requests: exactly one grant; losers wait, with no starvation. Worst-case wait is (N_REQ-1) draws.
- ack is never asserted for more than one bit, or for more than one cycle.
- Reset mid-operation: immediate return to IDLE with reset values; the in-flight draw is discarded with no ack.

Decomposition:
- Package random_server_pkg:
  - state_t enum (IDLE, STEP, SAMPLE, REDUCE, DONE).
  - Default constants: LFSR_WIDTH=16, RAND_OUT_W=10, RAND_STEP_CNT=4.
- Sub-module rr_arbiter:
  - Combinational round-robin pick from req and last_grant.
  - Outputs a one-hot grant and a grant index.
  - Parameterised by N_REQ.
- Top-level random_server instantiates rr_arbiter. The LFSR itself stays instantiated by the parent, next to random_server.

Test Plan:
- Reset, then a single req[0]=1 with range0=100 and a stub lfsr_random=16'h03FF -> lfsr_enable high for exactly 4 cycles; ack=3'b001 after 15 edges; value=23.
- req=3'b111 held continuously, each draw acked and dropped for one cycle -> ack order 0,1,2,0,1,2; no ack overlaps; busy low for exactly one cycle between draws.
- range=0 with stub 16'hFFFF -> value=1023. range=1 -> value=0. range=1023 with stub 16'h03FF -> value=0.
- Change range1 from 50 to 7 in the cycle after grant of requester 1, with stub 16'h0064 -> value=0 (100 mod 50, latched range).
- Assert rst during REDUCE -> ack stays 0, busy=0, lfsr_enable=0 immediately. With req held high, a fresh grant follows reset release starting from requester 0.
- Real LFSR attached, 1000 draws with range=37 -> every value < 37; all values 0..36 occur.

Source files
------------

// File: rtl/random_server_pkg.sv
// ---------------------------------------------------------------------------
// random_server_pkg
// Shared types and default constants for the random_server front end and
// its round-robin arbiter.
//   state_t      : service FSM states
//   LFSR_WIDTH   : default width of the LFSR state seen on lfsr_random
//   RAND_OUT_W   : default width of range / value
//   RAND_STEP_CNT: default LFSR shifts per draw
//   RAND_N_REQ   : default number of requesters
//   idx_w()      : index width for n items, never below one bit
// ---------------------------------------------------------------------------
package random_server_pkg;

   localparam int LFSR_WIDTH    = 16;
   localparam int RAND_OUT_W    = 10;
   localparam int RAND_STEP_CNT = 4;
   localparam int RAND_N_REQ    = 3;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      SAMPLE,
      REDUCE,
      DONE
   } state_t;

   // Width needed to index n items; a single item still gets one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one position above
// last_grant and wraps, so the most recently served requester has the
// lowest priority.
//   req         in  N_REQ  request vector
//   last_grant  in  IDX_W  index of the previously served requester
//   grant_oh    out N_REQ  one-hot winner (all zero when no request)
//   grant_idx   out IDX_W  index of the winner
//   grant_valid out 1      a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter
   import random_server_pkg::*;
#(
   parameter int N_REQ = RAND_N_REQ,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant_oh,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   int cand;

   // NOTE: every output of a combinational block is given a default before
   // any branch; a path that leaves one unassigned would infer a latch.
   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         // last_grant < N_REQ and off <= N_REQ, so one subtraction wraps it.
         cand = int'(last_grant) + off;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(cand);
            grant_oh    = N_REQ'(1) << cand;
         end
      end
   end

endmodule

// File: rtl/random_server.sv
// ---------------------------------------------------------------------------
// random_server
// Time-shared front end for the single LFSR random generator. Requesters are
// served one at a time in round-robin order. Each draw shifts the LFSR
// STEP_CNT times, samples its low OUT_W bits and reduces them modulo the
// requester's range with an OUT_W-cycle restoring remainder, so every draw
// has the same latency whatever the range.
//   clk          in  1            system clock
//   rst          in  1            asynchronous active-high reset
//   req          in  N_REQ        level requests, one bit per requester
//   range        in  N_REQ*OUT_W  exclusive upper bounds, slice i for req i
//   ack          out N_REQ        one-cycle pulse to the served requester
//   value        out OUT_W        result of the last draw (valid with ack)
//   busy         out 1            FSM is not in IDLE
//   lfsr_enable  out 1            shift enable for the external LFSR
//   lfsr_random  in  WIDTH        LFSR state
// ---------------------------------------------------------------------------
module random_server
   import random_server_pkg::*;
#(
   parameter int N_REQ    = RAND_N_REQ,
   parameter int WIDTH    = LFSR_WIDTH,
   parameter int OUT_W    = RAND_OUT_W,
   parameter int STEP_CNT = RAND_STEP_CNT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*OUT_W-1:0] range,
   output logic [N_REQ-1:0]       ack,
   output logic [OUT_W-1:0]       value,
   output logic                   busy,
   output logic                   lfsr_enable,
   input  logic [WIDTH-1:0]       lfsr_random
);

   localparam int IDX_W = idx_w(N_REQ);
   localparam int REM_W = 2 * OUT_W;
   localparam int K_W   = idx_w(OUT_W);
   localparam int CNT_W = idx_w(STEP_CNT);

   // ---------------------------------------------------------------- state
   state_t             state_q,      state_d;
   logic [IDX_W-1:0]   grant_q,      grant_d;
   logic [N_REQ-1:0]   grant_oh_q,   grant_oh_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [OUT_W-1:0]   range_q,      range_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [K_W-1:0]     k_q,          k_d;
   logic [REM_W-1:0]   rem_q,        rem_d;
   logic [N_REQ-1:0]   ack_q,        ack_d;
   logic [OUT_W-1:0]   value_q,      value_d;
   logic               busy_q,       busy_d;
   logic               lfsr_en_q,    lfsr_en_d;

   // ------------------------------------------------------------- arbiter
   logic [N_REQ-1:0]   arb_oh;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant_oh    (arb_oh),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // Only the low OUT_W bits of the LFSR state are ever sampled.
   generate
      if (WIDTH > OUT_W) begin : g_lfsr_hi
         logic lfsr_hi_unused;
         assign lfsr_hi_unused = ^lfsr_random[WIDTH-1:OUT_W];
      end
   endgenerate

   // Divisor aligned to the current restoring step. range_q < 2^OUT_W and
   // k_q < OUT_W, so the shift always fits in REM_W bits.
   logic [REM_W-1:0] div_shift;
   assign div_shift = REM_W'(range_q) << k_q;

   // ------------------------------------------------- next-state / outputs
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_oh_d   = grant_oh_q;
      last_grant_d = last_grant_q;
      range_d      = range_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      rem_d        = rem_q;
      ack_d        = '0;
      value_d      = value_q;
      lfsr_en_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               // Range is captured here so later changes cannot affect
               // the draw in flight.
               grant_d    = arb_idx;
               grant_oh_d = arb_oh;
               range_d    = range[int'(arb_idx)*OUT_W +: OUT_W];
               cnt_d      = '0;
               lfsr_en_d  = 1'b1;
               state_d    = STEP;
            end
         end

         STEP: begin
            // Enable is registered: it rose on the granting edge and stays
            // up until cnt reaches STEP_CNT-1, i.e. STEP_CNT cycles in all.
            if (cnt_q == CNT_W'(STEP_CNT - 1)) begin
               state_d = SAMPLE;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               lfsr_en_d = 1'b1;
            end
         end

         SAMPLE: begin
            rem_d   = REM_W'(lfsr_random[OUT_W-1:0]);
            k_d     = K_W'(OUT_W - 1);
            state_d = REDUCE;
         end

         REDUCE: begin
            // A zero range subtracts zero every step, leaving the raw sample.
            if (rem_q >= div_shift) begin
               rem_d = rem_q - div_shift;
            end
            if (k_q == '0) begin
               ack_d        = grant_oh_q;
               value_d      = rem_d[OUT_W-1:0];
               last_grant_d = grant_q;
               state_d      = DONE;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // ------------------------------------------------------------ registers
   // NOTE: state is updated only with non-blocking assignments so that every
   // flop samples the values from before the edge, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         grant_oh_q   <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
         range_q      <= '0;
         cnt_q        <= '0;
         k_q          <= '0;
         rem_q        <= '0;
         ack_q        <= '0;
         value_q      <= '0;
         busy_q       <= 1'b0;
         lfsr_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_oh_q   <= grant_oh_d;
         last_grant_q <= last_grant_d;
         range_q      <= range_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         rem_q        <= rem_d;
         ack_q        <= ack_d;
         value_q      <= value_d;
         busy_q       <= busy_d;
         lfsr_en_q    <= lfsr_en_d;
      end
   end

   assign ack         = ack_q;
   assign value       = value_q;
   assign busy        = busy_q;
   assign lfsr_enable = lfsr_en_q;

endmodule

// File: tb/tb_random_server.sv
// ---------------------------------------------------------------------------
// tb_random_server
// Self-checking bench for random_server with default parameters. The LFSR
// input is either a constant stub or a bench-side 16-bit LFSR model clocked
// by lfsr_enable. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_random_server;

   localparam int N_REQ    = 3;
   localparam int WIDTH    = 16;
   localparam int OUT_W    = 10;
   localparam int STEP_CNT = 4;
   localparam int LAT_EDGES = STEP_CNT + OUT_W + 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [N_REQ-1:0]       req = '0;
   logic [N_REQ*OUT_W-1:0] rng_bus = '0;
   logic [N_REQ-1:0]       ack;
   logic [OUT_W-1:0]       value;
   logic                   busy;
   logic                   lfsr_enable;
   logic [WIDTH-1:0]       lfsr_random;

   logic [WIDTH-1:0]       stub = '0;
   logic [WIDTH-1:0]       lfsr_state = 16'hACE1;
   logic                   use_real = 1'b0;

   int total = 0;
   int bad   = 0;
   int ack_err = 0;
   logic [N_REQ-1:0] prev_ack = '0;

   always #5 clk = ~clk;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
   always @(posedge clk) begin
      if (lfsr_enable) begin
         lfsr_state <= {lfsr_state[14:0],
                        lfsr_state[15] ^ lfsr_state[13] ^ lfsr_state[12] ^ lfsr_state[10]};
      end
   end

   assign lfsr_random = use_real ? lfsr_state : stub;

   random_server #(
      .N_REQ    (N_REQ),
      .WIDTH    (WIDTH),
      .OUT_W    (OUT_W),
      .STEP_CNT (STEP_CNT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .range       (rng_bus),
      .ack         (ack),
      .value       (value),
      .busy        (busy),
      .lfsr_enable (lfsr_enable),
      .lfsr_random (lfsr_random)
   );

   // ack must never have two bits set nor stay high two cycles in a row.
   always @(negedge clk) begin
      if (!$onehot0(ack) || (ack != '0 && prev_ack != '0)) begin
         ack_err <= ack_err + 1;
      end
      prev_ack <= ack;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Waits (bounded) for any ack bit; counts falling edges and enable cycles.
   task automatic wait_ack(input string nm, output int cyc, output int en_cnt);
      logic seen;
      cyc = 0;
      en_cnt = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (lfsr_enable) en_cnt++;
         if (ack != '0) seen = 1'b1;
      end
      check({nm, " ack arrived"}, 32'(seen), 1);
   endtask

   typedef struct {
      logic [N_REQ-1:0]       req;
      logic [N_REQ*OUT_W-1:0] rng;
      logic [WIDTH-1:0]       stub;
      int                     exp_idx;
      int                     exp_val;
   } vec_t;

   vec_t vecs[10];

   // One complete draw from IDLE; returns at the falling edge of the IDLE
   // cycle that follows DONE.
   task automatic do_draw(input vec_t v, input string nm);
      int cyc, en_cnt;
      rng_bus = v.rng;
      stub    = v.stub;
      req     = v.req;
      wait_ack(nm, cyc, en_cnt);
      check({nm, " ack"},     32'(ack),   32'(N_REQ'(1) << v.exp_idx));
      check({nm, " value"},   32'(value), 32'(v.exp_val));
      check({nm, " latency"}, 32'(cyc - 1), LAT_EDGES);
      check({nm, " enables"}, 32'(en_cnt), STEP_CNT);
      req = '0;
      @(negedge clk);
      check({nm, " ack drop"}, 32'(ack),  0);
      check({nm, " idle"},     32'(busy), 0);
   endtask

   initial begin : main
      int cyc, en_cnt;
      int exp_v;
      int n_seen;
      bit seen_v [37];
      vec_t v;

      //                 req     {r2,    r1,     r0}                stub     idx val
      vecs[0] = '{3'b001, {10'd5,   10'd5,   10'd100 }, 16'h03FF, 0, 23 };
      vecs[1] = '{3'b010, {10'd5,   10'd0,   10'd5   }, 16'hFFFF, 1, 1023};
      vecs[2] = '{3'b100, {10'd1,   10'd5,   10'd5   }, 16'hFFFF, 2, 0  };
      vecs[3] = '{3'b001, {10'd5,   10'd5,   10'd1023}, 16'h03FF, 0, 0  };
      vecs[4] = '{3'b010, {10'd5,   10'd37,  10'd5   }, 16'h1234, 1, 9  };
      vecs[5] = '{3'b100, {10'd1000,10'd5,   10'd5   }, 16'hABCD, 2, 973};
      vecs[6] = '{3'b001, {10'd5,   10'd5,   10'd3   }, 16'h0005, 0, 2  };
      vecs[7] = '{3'b011, {10'd5,   10'd7,   10'd5   }, 16'h03E8, 1, 6  };
      vecs[8] = '{3'b101, {10'd255, 10'd5,   10'd5   }, 16'h0200, 2, 2  };
      vecs[9] = '{3'b111, {10'd5,   10'd5,   10'd512 }, 16'h0300, 0, 256};

      // ------------------------------------------------------ reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset ack",   32'(ack),         0);
      check("reset value", 32'(value),       0);
      check("reset busy",  32'(busy),        0);
      check("reset en",    32'(lfsr_enable), 0);

      // ------------------------------------------------------ table
      for (int i = 0; i < 10; i++) begin
         do_draw(vecs[i], $sformatf("vec%0d", i));
      end

      // ------------------------------------------- round robin, held reqs
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rng_bus = {10'd5, 10'd5, 10'd5};
      stub    = 16'h0155;                 // 341 mod 5 = 1
      req     = 3'b111;
      for (int i = 0; i < 6; i++) begin
         wait_ack($sformatf("rr%0d", i), cyc, en_cnt);
         check($sformatf("rr%0d ack", i),   32'(ack),   32'(3'b001 << (i % 3)));
         check($sformatf("rr%0d value", i), 32'(value), 1);
         if (i == 5) req = '0;
         else        req[i % 3] = 1'b0;
         @(negedge clk);
         check($sformatf("rr%0d gap busy", i), 32'(busy), 0);
         check($sformatf("rr%0d gap ack", i),  32'(ack),  0);
         if (i < 5) begin
            req[i % 3] = 1'b1;
            @(negedge clk);
            check($sformatf("rr%0d regrant busy", i), 32'(busy), 1);
         end
      end

      // ------------------------------------- range change after the grant
      rng_bus = {10'd5, 10'd50, 10'd5};
      stub    = 16'h0064;
      req     = 3'b010;
      @(negedge clk);
      rng_bus[2*OUT_W-1:OUT_W] = 10'd7;
      wait_ack("latch", cyc, en_cnt);
      check("latch ack",   32'(ack),   32'(3'b010));
      check("latch value", 32'(value), 0);
      req = '0;
      @(negedge clk);

      // ------------------------------------------ req dropped mid-service
      rng_bus = {10'd9, 10'd5, 10'd5};
      req     = 3'b100;
      repeat (3) @(negedge clk);
      req = '0;
      wait_ack("drop", cyc, en_cnt);
      check("drop ack",   32'(ack),   32'(3'b100));
      check("drop value", 32'(value), 1);
      @(negedge clk);

      // ------------------------------------------------ reset during REDUCE
      v = '{3'b001, {10'd5, 10'd5, 10'd5}, 16'h0066, 0, 2};
      do_draw(v, "pre");                   // leaves last_grant at 0, value 2
      req = 3'b011;                        // would go to 1 without the reset
      @(negedge clk);
      check("mid busy", 32'(busy), 1);
      repeat (9) @(negedge clk);           // now well inside REDUCE
      rst = 1'b1;
      #1;
      check("rst ack",   32'(ack),         0);
      check("rst busy",  32'(busy),        0);
      check("rst en",    32'(lfsr_enable), 0);
      check("rst value", 32'(value),       0);
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (ack != '0) cyc++;
      end
      check("rst no ack", 32'(cyc), 0);
      rst = 1'b0;
      wait_ack("post rst", cyc, en_cnt);
      check("post rst ack",   32'(ack),   32'(3'b001));
      check("post rst value", 32'(value), 2);
      req = '0;
      @(negedge clk);

      // --------------------------------------------------- real LFSR run
      use_real = 1'b1;
      rng_bus  = {10'd37, 10'd37, 10'd37};
      for (int i = 0; i < 37; i++) seen_v[i] = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         req = 3'b001;
         wait_ack("lfsr", cyc, en_cnt);
         exp_v = int'(lfsr_state[OUT_W-1:0]) % 37;
         check("lfsr bound", 32'(value < 37), 1);
         check("lfsr value", 32'(value), 32'(exp_v));
         if (value < 37) seen_v[value] = 1'b1;
         req = '0;
         @(negedge clk);
      end
      n_seen = 0;
      for (int i = 0; i < 37; i++) if (seen_v[i]) n_seen++;
      check("lfsr coverage", 32'(n_seen), 37);

      check("ack single pulse", 32'(ack_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
